// File: rtl/frame_reader_pkg.sv
// rtl/frame_reader_pkg.sv - shared types and constants for the frame buffer read scanner
package frame_reader_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = 2;
    localparam int CREDIT_W   = 3;
    localparam logic [CREDIT_W:0] CREDIT_LIMIT = 4'(FIFO_DEPTH);

    typedef struct packed {
        logic valid;
        logic line_end;
        logic frame_end;
    } tag_t;

endpackage

// File: rtl/frame_buffer_reader_fifo.sv
// rtl/frame_buffer_reader_fifo.sv - 4-entry output FIFO (reader_fifo) holding pixel plus line/frame flags
module reader_fifo
    import frame_reader_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [WIDTH-1:0]    push_data,
    input  logic                pop,
    output logic [WIDTH-1:0]    head,
    output logic                empty,
    output logic [CREDIT_W-1:0] count
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CREDIT_W'(1);
            else if (!push && pop) count <= count - CREDIT_W'(1);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/frame_buffer_reader.sv
// rtl/frame_buffer_reader.sv - raster-order frame buffer scanner with credit-limited output FIFO
// Optional FRAME_READER_PIXEL_DOUBLE_EN presents every pixel for two beats (2x horizontal upscale).
module frame_buffer_reader
    import frame_reader_pkg::*;
#(
    parameter int CAM_DATA_WIDTH = 12,
    parameter int CAM_LINE       = 9,
    parameter int CAM_PIXEL      = 10,
    parameter int RD_LATENCY     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_frame_start,
    input  logic [CAM_LINE-1:0]       i_imag_depth,
    input  logic [CAM_PIXEL-1:0]      i_imag_width,
    output logic                      o_re,
    output logic [CAM_LINE-1:0]       o_rd_line,
    output logic [CAM_PIXEL-1:0]      o_rd_pixel,
    input  logic [CAM_DATA_WIDTH-1:0] i_rd_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [CAM_DATA_WIDTH-1:0] o_data,
    output logic                      o_line_end,
    output logic                      o_frame_end,
    output logic                      o_busy
);

    localparam int ENTRY_W = CAM_DATA_WIDTH + 2;
    localparam logic [CAM_PIXEL-1:0] PIX_ONE  = 1;
    localparam logic [CAM_LINE-1:0]  LINE_ONE = 1;

    state_t                state;
    logic [CAM_LINE-1:0]   depth_q;
    logic [CAM_PIXEL-1:0]  width_q;
    logic [CREDIT_W-1:0]   inflight;
    logic [CREDIT_W-1:0]   fifo_count;
    tag_t                  tag_pipe [RD_LATENCY];
    tag_t                  tag_in;
    tag_t                  tag_out;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  flag_qual;
    logic                  last_pixel;
    logic                  last_line;
    logic [ENTRY_W-1:0]    head;

    assign last_pixel = (o_rd_pixel == width_q - PIX_ONE);
    assign last_line  = (o_rd_line == depth_q - LINE_ONE);

    // A read is only issued when a FIFO slot is already reserved for its return.
    assign o_re   = (state == READ) &&
                    (({1'b0, fifo_count} + {1'b0, inflight}) < CREDIT_LIMIT);
    assign o_busy = (state == READ) ||
                    ((state == DRAIN) && !((inflight == '0) && fifo_empty));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            depth_q    <= '0;
            width_q    <= '0;
            o_rd_line  <= '0;
            o_rd_pixel <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_frame_start) begin
                        depth_q    <= i_imag_depth;
                        width_q    <= i_imag_width;
                        o_rd_line  <= '0;
                        o_rd_pixel <= '0;
                        if ((i_imag_depth != '0) && (i_imag_width != '0)) state <= READ;
                    end
                end
                READ: begin
                    if (o_re) begin
                        if (last_pixel) begin
                            o_rd_pixel <= '0;
                            if (last_line) state <= DRAIN;
                            else           o_rd_line <= o_rd_line + LINE_ONE;
                        end else begin
                            o_rd_pixel <= o_rd_pixel + PIX_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if ((inflight == '0) && fifo_empty) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        tag_in.valid     = o_re;
        tag_in.line_end  = last_pixel;
        tag_in.frame_end = last_pixel && last_line;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign tag_out = tag_pipe[RD_LATENCY-1];
    assign push    = tag_out.valid;

    always_ff @(posedge clk) begin
        if (reset)               inflight <= '0;
        else if (o_re && !push)  inflight <= inflight + CREDIT_W'(1);
        else if (!o_re && push)  inflight <= inflight - CREDIT_W'(1);
    end

    reader_fifo #(.WIDTH(ENTRY_W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({tag_out.line_end, tag_out.frame_end, i_rd_data}),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign o_valid = !fifo_empty;

`ifdef FRAME_READER_PIXEL_DOUBLE_EN
    logic beat;

    always_ff @(posedge clk) begin
        if (reset)                   beat <= 1'b0;
        else if (o_valid && i_ready) beat <= ~beat;
    end

    assign pop       = o_valid && i_ready && beat;
    assign flag_qual = beat;
`else
    assign pop       = o_valid && i_ready;
    assign flag_qual = 1'b1;
`endif

    assign o_data      = head[CAM_DATA_WIDTH-1:0];
    assign o_line_end  = o_valid && flag_qual && head[ENTRY_W-1];
    assign o_frame_end = o_valid && flag_qual && head[ENTRY_W-2];

endmodule

// File: tb/tb_frame_buffer_reader.sv
// tb/tb_frame_buffer_reader.sv - table-driven scoreboard bench for frame_buffer_reader
module tb_frame_buffer_reader;

    localparam int DW  = 12;
    localparam int LW  = 9;
    localparam int PW  = 10;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_frame_start = 1'b0;
    logic [LW-1:0] i_imag_depth = '0;
    logic [PW-1:0] i_imag_width = '0;
    logic          o_re;
    logic [LW-1:0] o_rd_line;
    logic [PW-1:0] o_rd_pixel;
    logic [DW-1:0] i_rd_data;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_line_end;
    logic          o_frame_end;
    logic          o_busy;

    frame_buffer_reader #(
        .CAM_DATA_WIDTH(DW), .CAM_LINE(LW), .CAM_PIXEL(PW), .RD_LATENCY(LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_frame_start(i_frame_start),
        .i_imag_depth (i_imag_depth),
        .i_imag_width (i_imag_width),
        .o_re         (o_re),
        .o_rd_line    (o_rd_line),
        .o_rd_pixel   (o_rd_pixel),
        .i_rd_data    (i_rd_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_line_end   (o_line_end),
        .o_frame_end  (o_frame_end),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          le;
        logic          fe;
    } beat_t;

    typedef struct packed {
        logic          v;
        logic [LW-1:0] l;
        logic [PW-1:0] p;
    } rd_t;

    typedef struct {
        int w;
        int d;
        int mode;
        int exp_reads;
    } vec_t;

    beat_t sb[$];
    int    tests = 0;
    int    fails = 0;
    rd_t   mpipe [LAT];

    function automatic logic [DW-1:0] pix_val(input logic [LW-1:0] l, input logic [PW-1:0] p);
        logic [DW-1:0] lv;
        logic [DW-1:0] pv;
        lv = DW'(l);
        pv = DW'(p);
        return lv * 12'd37 + pv * 12'd5 + 12'd1;
    endfunction

    // Frame buffer model: data for an address appears LAT cycles after its read enable.
    always @(posedge clk) begin
        mpipe[0] <= {o_re, o_rd_line, o_rd_pixel};
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign i_rd_data = mpipe[LAT-1].v ? pix_val(mpipe[LAT-1].l, mpipe[LAT-1].p) : 12'hbad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input int w, input int d, input int mode, input int exp_reads);
        int    n_beats, got, reads, el, ep, t, first_re, first_v, last_acc, max_out;
        logic  bad, prev_hold;
        beat_t e, prev;
`ifdef FRAME_READER_PIXEL_DOUBLE_EN
        beat_t e0;
`endif
        sb.delete();
        for (int l = 0; l < d; l++) begin
            for (int p = 0; p < w; p++) begin
                e.data = pix_val(LW'(l), PW'(p));
                e.le   = (p == w - 1);
                e.fe   = (p == w - 1) && (l == d - 1);
`ifdef FRAME_READER_PIXEL_DOUBLE_EN
                e0 = e;
                e0.le = 1'b0;
                e0.fe = 1'b0;
                sb.push_back(e0);
`endif
                sb.push_back(e);
            end
        end
        n_beats = sb.size();
        got = 0; reads = 0; el = 0; ep = 0;
        first_re = -1; first_v = -1; last_acc = 0; max_out = 0;
        prev_hold = 1'b0; prev = '0;

        @(posedge clk); #1;
        i_imag_width  = PW'(w);
        i_imag_depth  = LW'(d);
        i_frame_start = 1'b1;
        i_ready       = 1'b1;
        @(posedge clk); #1;
        i_frame_start = 1'b0;

        if (exp_reads == 0) begin
            bad = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (o_re || o_busy || o_valid) bad = 1'b1;
                @(posedge clk); #1;
            end
            check("zero_dim_idle", 32'(bad), 32'(0));
            return;
        end

        check("first_re", 32'(o_re), 32'(1));
        check("busy_on", 32'(o_busy), 32'(1));

        for (t = 0; t < 20000 && got < n_beats; t++) begin
            case (mode)
                0:       i_ready = 1'b1;
                1:       i_ready = ((t % 2) == 0);
                2:       i_ready = 1'($urandom_range(0, 1));
                default: i_ready = !(t >= 6 && t < 26);
            endcase
            if (mode == 2 && t == 5) begin
                i_frame_start = 1'b1;
                i_imag_width  = PW'(2);
                i_imag_depth  = LW'(2);
            end
            if (mode == 2 && t == 6) i_frame_start = 1'b0;
            #1;
            if (o_re) begin
                check("rd_addr", 32'({o_rd_line, o_rd_pixel}), 32'({LW'(el), PW'(ep)}));
                reads++;
                if (first_re < 0) first_re = t;
                if (ep == w - 1) begin ep = 0; el++; end
                else ep++;
            end
            if (o_valid && first_v < 0) first_v = t;
            if (prev_hold) check("hold_stable", 32'({o_valid, o_data, o_line_end, o_frame_end}), 32'({1'b1, prev}));
            if (mode == 3 && t == 25) check("hold_re_stopped", 32'(o_re), 32'(0));
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check("extra_beat", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("beat", 32'({o_data, o_line_end, o_frame_end}), 32'(e));
                end
                got++;
                last_acc = t;
            end
            prev_hold = o_valid && !i_ready;
            prev      = {o_data, o_line_end, o_frame_end};
            if (reads - got > max_out) max_out = reads - got;
            @(posedge clk); #1;
        end

        if (got < n_beats) begin
            check("frame_timeout", 32'(got), 32'(n_beats));
        end else begin
            check("busy_off", 32'({o_busy, o_valid}), 32'(0));
            check("read_count", 32'(reads), 32'(exp_reads));
            check("max_outstanding_ok", 32'(max_out <= 4), 32'(1));
            check("first_valid_latency", 32'(first_v - first_re), 32'(LAT + 1));
            if (mode == 0) check("throughput", 32'(last_acc - first_v), 32'(n_beats - 1));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 32'({o_re, o_rd_line, o_rd_pixel, o_valid, o_data, o_line_end, o_frame_end, o_busy}), 32'(0));
    endtask

    vec_t vecs [8];

    initial begin
        int   n;
        logic stale;
        vecs[0] = '{w: 4,  d: 2,  mode: 0, exp_reads: 8};
        vecs[1] = '{w: 40, d: 30, mode: 1, exp_reads: 1200};
        vecs[2] = '{w: 7,  d: 3,  mode: 2, exp_reads: 21};
        vecs[3] = '{w: 10, d: 2,  mode: 3, exp_reads: 20};
        vecs[4] = '{w: 1,  d: 1,  mode: 0, exp_reads: 1};
        vecs[5] = '{w: 0,  d: 5,  mode: 0, exp_reads: 0};
        vecs[6] = '{w: 5,  d: 0,  mode: 0, exp_reads: 0};
        vecs[7] = '{w: 2,  d: 1,  mode: 0, exp_reads: 2};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_frame(vecs[i].w, vecs[i].d, vecs[i].mode, vecs[i].exp_reads);

        // Abort a frame with reads still outstanding.
        @(posedge clk); #1;
        i_imag_width  = PW'(8);
        i_imag_depth  = LW'(2);
        i_frame_start = 1'b1;
        i_ready       = 1'b0;
        @(posedge clk); #1;
        i_frame_start = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && n < 3; k++) begin
            if (o_re) n++;
            @(posedge clk); #1;
        end
        check("reads_before_reset", 32'(n), 32'(3));
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("mid_frame_reset");
        reset   = 1'b0;
        i_ready = 1'b1;
        stale   = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (o_valid || o_re || o_busy) stale = 1'b1;
            @(posedge clk); #1;
        end
        check("no_stale_after_reset", 32'(stale), 32'(0));

        run_frame(3, 2, 0, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
